// File: rtl/tcls_resync_ctrl.sv
// Resynchronization sequencer for a triple-core lock-step cluster: unload, optional setback,
// reload, bounded retries. Watchdog present only when TCLS_RESYNC_TIMEOUT_EN is defined.
module tcls_resync_ctrl #(
    parameter int unsigned TimeoutWidth  = 16,
    parameter int unsigned MaxRetries    = 3,
    parameter int unsigned SetbackCycles = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fetch_en_i,
    input  logic [2:0]              mismatch_i,
    input  logic                    force_resynch_i,
    input  logic                    unload_done_i,
    input  logic                    reload_done_i,
    input  logic                    setback_en_i,
    input  logic [TimeoutWidth-1:0] timeout_i,
    output logic                    resynch_req_o,
    output logic [2:0]              setback_o,
    output logic                    busy_o,
    output logic                    fail_o,
    output logic [2:0]              state_o,
    output logic [2:0]              faulty_o,
    output logic [3:0]              retry_cnt_o
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_UNLOAD  = 3'd1,
        ST_SETBACK = 3'd2,
        ST_RELOAD  = 3'd3,
        ST_FAIL    = 3'd4
    } state_e;

    localparam int unsigned SbW        = (SetbackCycles > 1) ? $clog2(SetbackCycles) : 1;
    localparam logic [SbW-1:0] SbLast  = SbW'(SetbackCycles - 1);
    localparam logic [3:0]     RetryLast = 4'(MaxRetries - 1);

    state_e         state_q, state_d;
    logic [2:0]     faulty_q, faulty_d;
    logic [3:0]     retry_q, retry_d;
    logic [SbW-1:0] sb_cnt_q;
    logic           resynch_req_q, busy_q, fail_q;
    logic [2:0]     setback_q;
    logic           wd_expire;

`ifdef TCLS_RESYNC_TIMEOUT_EN
    logic [TimeoutWidth-1:0] wd_cnt_q;

    assign wd_expire = (timeout_i != '0) && (wd_cnt_q == timeout_i - TimeoutWidth'(1));

    // Saturating cycle counter, restarted on every state change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else if (state_d != state_q) begin
            wd_cnt_q <= '0;
        end else if ((state_q == ST_UNLOAD || state_q == ST_RELOAD) && wd_cnt_q != '1) begin
            wd_cnt_q <= wd_cnt_q + TimeoutWidth'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_i;
    assign wd_expire      = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        faulty_d = faulty_q;
        retry_d  = retry_q;
        if (!fetch_en_i) begin
            state_d  = ST_RUN;
            faulty_d = '0;
            retry_d  = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mismatch_i != '0 || force_resynch_i) begin
                        state_d  = ST_UNLOAD;
                        faulty_d = mismatch_i;
                        retry_d  = '0;
                    end
                end
                ST_UNLOAD: begin
                    faulty_d = faulty_q | mismatch_i;
                    if (unload_done_i) begin
                        state_d = setback_en_i ? ST_SETBACK : ST_RELOAD;
                    end else if (wd_expire) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_SETBACK: begin
                    if (sb_cnt_q == SbLast) begin
                        state_d = ST_RELOAD;
                    end
                end
                ST_RELOAD: begin
                    if (reload_done_i) begin
                        state_d = ST_RUN;
                    end else if (mismatch_i != '0) begin
                        faulty_d = faulty_q | mismatch_i;
                        if (retry_q == RetryLast) begin
                            state_d = ST_FAIL;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            if (setback_en_i) begin
                                state_d = ST_SETBACK;
                            end
                        end
                    end else if (wd_expire) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_FAIL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            faulty_q      <= '0;
            retry_q       <= '0;
            sb_cnt_q      <= '0;
            resynch_req_q <= 1'b0;
            setback_q     <= '0;
            busy_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            faulty_q      <= faulty_d;
            retry_q       <= retry_d;
            sb_cnt_q      <= (state_q == ST_SETBACK && state_d == ST_SETBACK) ? sb_cnt_q + SbW'(1) : '0;
            resynch_req_q <= (state_d == ST_UNLOAD);
            setback_q     <= {3{state_d == ST_SETBACK}};
            busy_q        <= (state_d != ST_RUN);
            fail_q        <= fetch_en_i && (fail_q || state_d == ST_FAIL);
        end
    end

    assign state_o       = state_q;
    assign faulty_o      = faulty_q;
    assign retry_cnt_o   = retry_q;
    assign resynch_req_o = resynch_req_q;
    assign setback_o     = setback_q;
    assign busy_o        = busy_q;
    assign fail_o        = fail_q;

endmodule

// File: tb/tb_tcls_resync_ctrl.sv
// Scoreboard bench for tcls_resync_ctrl: directed recovery scenarios followed by random traffic,
// checked cycle by cycle against a reference model of the recovery rules.
module tb_tcls_resync_ctrl;

    localparam int TW          = 16;
    localparam int MAX_RETRIES = 3;
    localparam int SB_CYC      = 4;

    localparam int M_RUN = 0, M_UNLOAD = 1, M_SETBACK = 2, M_RELOAD = 3, M_FAIL = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, fetch_en_i, force_resynch_i, unload_done_i, reload_done_i, setback_en_i;
    logic [2:0]    mismatch_i;
    logic [TW-1:0] timeout_i;
    logic          resynch_req_o, busy_o, fail_o;
    logic [2:0]    setback_o, state_o, faulty_o;
    logic [3:0]    retry_cnt_o;

    tcls_resync_ctrl #(
        .TimeoutWidth (TW),
        .MaxRetries   (MAX_RETRIES),
        .SetbackCycles(SB_CYC)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fetch_en_i     (fetch_en_i),
        .mismatch_i     (mismatch_i),
        .force_resynch_i(force_resynch_i),
        .unload_done_i  (unload_done_i),
        .reload_done_i  (reload_done_i),
        .setback_en_i   (setback_en_i),
        .timeout_i      (timeout_i),
        .resynch_req_o  (resynch_req_o),
        .setback_o      (setback_o),
        .busy_o         (busy_o),
        .fail_o         (fail_o),
        .state_o        (state_o),
        .faulty_o       (faulty_o),
        .retry_cnt_o    (retry_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       rq;
        logic [2:0] sb;
        logic       busy;
        logic       fail;
        logic [2:0] faulty;
        logic [3:0] retry;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: phase, cycles spent in the phase, accumulated mask and retry count.
    int         m_st, m_age, m_retry;
    logic [2:0] m_faulty;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check("state",   e.cyc, 32'(state_o),       32'(e.st));
            check("resynch", e.cyc, 32'(resynch_req_o), 32'(e.rq));
            check("setback", e.cyc, 32'(setback_o),     32'(e.sb));
            check("busy",    e.cyc, 32'(busy_o),        32'(e.busy));
            check("fail",    e.cyc, 32'(fail_o),        32'(e.fail));
            check("faulty",  e.cyc, 32'(faulty_o),      32'(e.faulty));
            check("retry",   e.cyc, 32'(retry_cnt_o),   32'(e.retry));
        end
    end

    task automatic model_clear();
        m_st = M_RUN; m_age = 0; m_retry = 0; m_faulty = 3'b000;
    endtask

    task automatic model_step(input logic [2:0] mm, input logic fr, input logic ud, input logic rd);
        int nxt;
        bit wd;
        if (rst_i || !fetch_en_i) begin
            model_clear();
            return;
        end
`ifdef TCLS_RESYNC_TIMEOUT_EN
        wd = (timeout_i != 0) && (m_age + 1 == int'(timeout_i));
`else
        wd = 1'b0;
`endif
        nxt = m_st;
        case (m_st)
            M_RUN: if (mm != 0 || fr) begin
                nxt = M_UNLOAD; m_faulty = mm; m_retry = 0;
            end
            M_UNLOAD: begin
                m_faulty |= mm;
                if (ud) nxt = setback_en_i ? M_SETBACK : M_RELOAD;
                else if (wd) nxt = M_FAIL;
            end
            M_SETBACK: if (m_age + 1 == SB_CYC) nxt = M_RELOAD;
            M_RELOAD: begin
                if (rd) nxt = M_RUN;
                else if (mm != 0) begin
                    m_faulty |= mm;
                    if (m_retry + 1 == MAX_RETRIES) nxt = M_FAIL;
                    else begin
                        m_retry++;
                        if (setback_en_i) nxt = M_SETBACK;
                    end
                end else if (wd) nxt = M_FAIL;
            end
            default: ;
        endcase
        m_age = (nxt != m_st) ? 0 : m_age + 1;
        m_st  = nxt;
    endtask

    task automatic push_exp(input int c);
        exp_t e;
        e.cyc    = c;
        e.st     = 3'(m_st);
        e.rq     = (m_st == M_UNLOAD);
        e.sb     = (m_st == M_SETBACK) ? 3'b111 : 3'b000;
        e.busy   = (m_st != M_RUN);
        e.fail   = (m_st == M_FAIL);
        e.faulty = m_faulty;
        e.retry  = 4'(m_retry);
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs; the model predicts the outputs after the next edge.
    task automatic cycle(input logic [2:0] mm, input logic fr, input logic ud, input logic rd);
        mismatch_i = mm; force_resynch_i = fr; unload_done_i = ud; reload_done_i = rd;
        model_step(mm, fr, ud, rd);
        push_exp(cyc + 1);
        @(posedge clk_i); #1;
        mismatch_i = 3'b000; force_resynch_i = 1'b0; unload_done_i = 1'b0; reload_done_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle: outputs must already be clear in this same cycle.
    task automatic async_reset();
        rst_i = 1'b1;
        model_clear();
        if (sb_q.size() > 0 && sb_q[$].cyc == cyc) void'(sb_q.pop_back());
        push_exp(cyc);
        idle(2);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; fetch_en_i = 1'b1; setback_en_i = 1'b1; timeout_i = '0;
        mismatch_i = 3'b000; force_resynch_i = 1'b0; unload_done_i = 1'b0; reload_done_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        push_exp(cyc);
        rst_i = 1'b0;

        // Single-core mismatch with setback.
        cycle(3'b010, 1'b0, 1'b0, 1'b0);
        idle(4);
        cycle(3'b000, 1'b0, 1'b1, 1'b0);
        idle(6);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Software force without setback.
        setback_en_i = 1'b0;
        cycle(3'b000, 1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(3'b000, 1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Retry exhaustion ending in sticky FAIL.
        setback_en_i = 1'b1;
        cycle(3'b001, 1'b0, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b1, 1'b0);
        idle(5);
        cycle(3'b001, 1'b0, 1'b0, 1'b0);
        idle(5);
        cycle(3'b100, 1'b0, 1'b0, 1'b0);
        idle(5);
        cycle(3'b001, 1'b0, 1'b0, 1'b0);
        idle(8);
        cycle(3'b000, 1'b0, 1'b0, 1'b1);
        fetch_en_i = 1'b0;
        idle(1);
        fetch_en_i = 1'b1;
        idle(2);

        // Watchdog in UNLOAD, then a long wait.
        timeout_i = TW'(10);
        cycle(3'b000, 1'b1, 1'b0, 1'b0);
        idle(1000);
        fetch_en_i = 1'b0;
        idle(1);
        fetch_en_i = 1'b1;
        timeout_i = '0;

        // Reload done wins over a simultaneous mismatch.
        setback_en_i = 1'b0;
        cycle(3'b000, 1'b1, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b1, 1'b0);
        cycle(3'b010, 1'b0, 1'b0, 1'b0);
        cycle(3'b001, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset during SETBACK, fetch_en low during UNLOAD.
        setback_en_i = 1'b1;
        cycle(3'b000, 1'b1, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b1, 1'b0);
        idle(1);
        async_reset();
        cycle(3'b100, 1'b0, 1'b0, 1'b0);
        idle(1);
        fetch_en_i = 1'b0;
        idle(1);
        fetch_en_i = 1'b1;
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] mm;
            if ($urandom_range(0, 299) == 0) async_reset();
            fetch_en_i = ($urandom_range(0, 59) != 0);
            if (m_st == M_RUN && $urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0:       timeout_i = TW'(0);
                    1:       timeout_i = TW'(1);
                    2:       timeout_i = TW'(3);
                    3:       timeout_i = TW'(10);
                    default: timeout_i = TW'(40);
                endcase
            end
            if ($urandom_range(0, 39) == 0) setback_en_i = 1'($urandom_range(0, 1));
            mm = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            cycle(mm, $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk_i);
        check("drain", cyc, 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tcls_resync_ctrl.md
# tcls_resync_ctrl

Sequencer for triple-core lock-step resynchronization.
- Takes per-core mismatch flags from the TMR voters and a software force request, then drives the full recovery sequence: unload request to software, optional core setback, reload, then back to lock-step run.
- Adds a bounded retry count for mismatches during reload and a watchdog timeout, so a recovery that never completes ends in a sticky failure state.
- Sits beside the lock-step voter/mux in each TCLS cluster, between the voter error outputs, the manager register file and the cores' setback inputs.

## Interface
Parameters:
- TimeoutWidth, 16: width of the watchdog compare value and counter.
- MaxRetries, 3: number of reload-phase mismatches tolerated before FAIL; range 1–15.
- SetbackCycles, 4: cycles `setback_o` stays asserted per setback; must be ≥ 1.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- fetch_en_i  in  1  cluster fetch enable; low forces RUN and clears all state.
- mismatch_i  in  3  per-core mismatch flags from the voters (bit i = core i outvoted).
- force_resynch_i  in  1  software-requested resynchronization, one-cycle pulse.
- unload_done_i  in  1  pulse: software finished storing state (stack-pointer store written non-zero).
- reload_done_i  in  1  pulse: software finished restoring state (stack-pointer store cleared).
- setback_en_i  in  1  config: apply core setback between unload and reload.
- timeout_i  in  TimeoutWidth  config: watchdog limit in cycles; 0 disables the watchdog.
- resynch_req_o  out  1  resynchronization interrupt request to the cores.
- setback_o  out  3  per-core setback, all three bits driven together.
- busy_o  out  1  high in any state other than RUN.
- fail_o  out  1  sticky failure flag.
- state_o  out  3  current state: RUN=0, UNLOAD=1, SETBACK=2, RELOAD=3, FAIL=4.
- faulty_o  out  3  accumulated mask of cores that mismatched in the current episode.
- retry_cnt_o  out  4  number of reload-phase mismatches in the current episode.

## Operation
- RUN:
  - `mismatch_i != 0` or `force_resynch_i` → UNLOAD.
  - On entry, `faulty_q` is loaded with `mismatch_i` and `retry_cnt` is cleared.
- UNLOAD:
  - `resynch_req_o` = 1.
  - Further `mismatch_i` bits are ORed into `faulty_q`.
  - `unload_done_i` → SETBACK if `setback_en_i`, else → RELOAD.
- SETBACK:
  - `setback_o` = 3'b111 for exactly SetbackCycles cycles, counted by a dedicated counter, then → RELOAD.
  - Mismatches are ignored in this state.
- RELOAD:
  - `reload_done_i` → RUN.
  - Otherwise, `mismatch_i != 0`:
    - `faulty_q |= mismatch_i`;
    - if `retry_cnt == MaxRetries-1` → FAIL;
    - else `retry_cnt++` and → SETBACK if `setback_en_i`, else stay in RELOAD.
- FAIL:
  - `fail_o` = 1 and `busy_o` = 1.
  - The only exits are `fetch_en_i` low or reset.
- Watchdog:
  - The cycle counter clears on every state entry and increments in UNLOAD and RELOAD.
  - When `timeout_i != 0` and the count reaches `timeout_i - 1` without an exit event → FAIL.
  - The counter saturates; it never wraps.
- Priorities, highest first:
  1. `rst_i`
  2. `fetch_en_i` low → RUN, clearing `faulty_q`, `retry_cnt` and `fail_o`
  3. done pulses
  4. mismatch
  5. watchdog expiry
- A done pulse arriving in a state that does not consume it is dropped.
- `force_resynch_i` outside RUN is dropped.

## Timing
- All outputs are registered. Every output resets to 0, which means `state_o` = RUN.
- A mismatch sampled in cycle N gives `state_o` = UNLOAD and `resynch_req_o` = 1 in cycle N+1.
- `setback_o` rises the cycle after the `unload_done_i` sample and falls exactly SetbackCycles cycles later. RELOAD is entered in that same cycle.
- `resynch_req_o` falls on the same edge on which UNLOAD is left.
- Reset asserted mid-sequence: every output clears asynchronously and `setback_o` is cut immediately.

## Configuration
- `TCLS_RESYNC_TIMEOUT_EN` defined: watchdog counter and comparator are present as described.
- Not defined:
  - counter and comparator are not built;
  - `timeout_i` is ignored;
  - FAIL is reachable only through retry exhaustion;
  - UNLOAD and RELOAD wait indefinitely.

## Test plan
- `mismatch_i`=3'b010 for 1 cycle, `unload_done_i` 5 cycles later with `setback_en_i`=1, `reload_done_i` 3 cycles after `setback_o` falls → states 0→1→2→3→0; `setback_o`=3'b111 for 4 cycles; `faulty_o`=3'b010; `fail_o`=0.
- `setback_en_i`=0, `force_resynch_i` pulse → UNLOAD, then RELOAD directly on `unload_done_i`, with `setback_o` never asserted; `faulty_o`=0.
- MaxRetries=3, mismatches 3'b001, 3'b100, 3'b001 during successive RELOAD phases → `retry_cnt_o` goes 1, then 2, then `state_o`=4; `fail_o`=1; `faulty_o`=3'b101; stays in FAIL until `fetch_en_i` goes low.
- `timeout_i`=10, no `unload_done_i` → FAIL 10 cycles after entering UNLOAD with the macro defined; still in UNLOAD after 1000 cycles without it.
- `reload_done_i` and `mismatch_i`=3'b001 in the same cycle → RUN, with `retry_cnt_o` unchanged.
- `rst_i` pulse during SETBACK → all outputs 0 in the same cycle; `fetch_en_i` low during UNLOAD → RUN next cycle with `resynch_req_o`=0.
